// File: rtl/cntr_seq_checker.sv
// Receive-side checker for a free-running WIDTH-bit counter stream and its divided clock.
// Locks onto the +1 sequence, counts errors while locked, and re-acquires after a loss of lock.
module cntr_seq_checker #(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             CLK,
  input  logic             RST_B,
  input  logic             EN,
  input  logic             CLR_ERR,
  input  logic [WIDTH-1:0] CNTR_IN,
  input  logic             DIV_IN,
  output logic             LOCKED,
  output logic             ERR_PULSE,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             DIV_ERR,
  output logic [1:0]       STATE
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2,
    S_LOST   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] prev_reg, prev_next;
  logic [GW-1:0]    good_run_reg, good_run_next;
  logic [BW-1:0]    bad_run_reg, bad_run_next;
  logic             div_prev_reg, div_prev_next;
  logic             locked_reg, locked_next;
  logic             err_pulse_reg, err_pulse_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;
  logic             div_err_reg, div_err_next;

  logic [WIDTH-1:0] expected;
  logic             match;
  logic             seq_err;
  logic             div_fault;

  assign expected = prev_reg + WIDTH'(1);
  assign match    = (CNTR_IN == expected);

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_reg     <= S_IDLE;
      prev_reg      <= '0;
      good_run_reg  <= '0;
      bad_run_reg   <= '0;
      div_prev_reg  <= 1'b0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_cnt_reg   <= '0;
      div_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prev_reg      <= prev_next;
      good_run_reg  <= good_run_next;
      bad_run_reg   <= bad_run_next;
      div_prev_reg  <= div_prev_next;
      locked_reg    <= locked_next;
      err_pulse_reg <= err_pulse_next;
      err_cnt_reg   <= err_cnt_next;
      div_err_reg   <= div_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    prev_next     = prev_reg;
    good_run_next = good_run_reg;
    bad_run_next  = bad_run_reg;
    div_prev_next = div_prev_reg;
    seq_err       = 1'b0;
    div_fault     = 1'b0;
    if (!EN) begin
      state_next    = S_IDLE;
      good_run_next = '0;
      bad_run_next  = '0;
    end else begin
      div_prev_next = DIV_IN;
      case (state_reg)
        S_IDLE: begin
          prev_next     = CNTR_IN;
          good_run_next = '0;
          state_next    = S_ACQ;
        end
        S_ACQ: begin
          prev_next = CNTR_IN;
          if (match) begin
            good_run_next = good_run_reg + GW'(1);
            if (good_run_reg == GW'(LOCK_CNT - 1)) begin
              state_next   = S_LOCKED;
              bad_run_next = '0;
            end
          end else begin
            good_run_next = '0;
          end
        end
        S_LOCKED: begin
          // Flywheel: advance on the expected value so one bad sample costs one error.
          prev_next = expected;
          if (!match) begin
            seq_err      = 1'b1;
            bad_run_next = bad_run_reg + BW'(1);
            if (bad_run_reg == BW'(LOSS_CNT - 1)) begin
              state_next = S_LOST;
            end
          end else begin
            bad_run_next = '0;
          end
          div_fault = (DIV_IN == div_prev_reg);
        end
        default: begin
          prev_next     = CNTR_IN;
          good_run_next = '0;
          state_next    = S_ACQ;
        end
      endcase
    end
  end

  always_comb begin
    err_pulse_next = seq_err;
    err_cnt_next   = err_cnt_reg;
    div_err_next   = div_err_reg;
    locked_next    = (state_next == S_LOCKED);
    // A clear wins over an error in the same cycle; the pulse still fires.
    if (CLR_ERR) begin
      err_cnt_next = '0;
      div_err_next = 1'b0;
    end else begin
      if (seq_err && (err_cnt_reg != {ERR_W{1'b1}})) begin
        err_cnt_next = err_cnt_reg + ERR_W'(1);
      end
      if (div_fault) begin
        div_err_next = 1'b1;
      end
    end
  end

  assign LOCKED    = locked_reg;
  assign ERR_PULSE = err_pulse_reg;
  assign ERR_CNT   = err_cnt_reg;
  assign DIV_ERR   = div_err_reg;
  assign STATE     = state_reg;

endmodule

// File: tb/tb_cntr_seq_checker.sv
// Bench for cntr_seq_checker: table-driven lock/wrap/glitch vectors, directed corner
// sequences, then random stimulus against a behavioural model (two ERR_W variants).
module tb_cntr_seq_checker;

  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       en = 1'b0;
  logic       clr_err = 1'b0;
  logic [2:0] cntr_in = '0;
  logic       div_in = 1'b0;

  logic       locked, err_pulse, div_err;
  logic [7:0] err_cnt;
  logic [1:0] state;
  logic       locked_s, err_pulse_s, div_err_s;
  logic [1:0] err_cnt_s;
  logic [1:0] state_s;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_state, m_prev, m_good, m_bad, m_divprev, m_errs;
  bit m_pulse, m_diverr;
  int cv;
  bit div_q;

  typedef struct {
    bit en;
    bit clr;
    int cntr;
    bit div;
    int state;
    bit locked;
    bit pulse;
    int errcnt;
  } vec_t;
  vec_t tbl[16];

  always #5 clk = ~clk;

  cntr_seq_checker #(.WIDTH(3), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(8)) dut (
    .CLK(clk), .RST_B(rst_b), .EN(en), .CLR_ERR(clr_err), .CNTR_IN(cntr_in), .DIV_IN(div_in),
    .LOCKED(locked), .ERR_PULSE(err_pulse), .ERR_CNT(err_cnt), .DIV_ERR(div_err), .STATE(state)
  );

  cntr_seq_checker #(.WIDTH(3), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(2)) dut_sat (
    .CLK(clk), .RST_B(rst_b), .EN(en), .CLR_ERR(clr_err), .CNTR_IN(cntr_in), .DIV_IN(div_in),
    .LOCKED(locked_s), .ERR_PULSE(err_pulse_s), .ERR_CNT(err_cnt_s), .DIV_ERR(div_err_s), .STATE(state_s)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_state = 0; m_prev = 0; m_good = 0; m_bad = 0; m_divprev = 0;
    m_errs = 0; m_pulse = 0; m_diverr = 0;
  endtask

  // Errors are kept as an unbounded total since the last clear; each counter width saturates it.
  task automatic model_step(input bit e, input bit c, input int v, input bit d);
    int  expv;
    bit  err;
    bit  dfault;
    expv = (m_prev + 1) % 8;
    err = 0;
    dfault = 0;
    if (!e) begin
      m_state = 0; m_good = 0; m_bad = 0;
    end else begin
      case (m_state)
        0: begin m_prev = v; m_good = 0; m_state = 1; end
        1: begin
          m_good = (v == expv) ? m_good + 1 : 0;
          m_prev = v;
          if (m_good == LOCK_CNT) begin m_state = 2; m_bad = 0; end
        end
        2: begin
          m_prev = expv;
          err = (v != expv);
          m_bad = err ? m_bad + 1 : 0;
          if (m_bad == LOSS_CNT) m_state = 3;
          dfault = (d == m_divprev);
        end
        default: begin m_prev = v; m_good = 0; m_state = 1; end
      endcase
      m_divprev = d;
    end
    m_pulse = err;
    if (c) begin
      m_errs = 0; m_diverr = 0;
    end else begin
      m_errs += err;
      if (dfault) m_diverr = 1;
    end
  endtask

  task automatic compare_model();
    chk("state", state, m_state);
    chk("locked", locked, (m_state == 2) ? 1 : 0);
    chk("err_pulse", err_pulse, m_pulse);
    chk("err_cnt", err_cnt, min_i(m_errs, 255));
    chk("div_err", div_err, m_diverr);
    chk("sat_err_cnt", err_cnt_s, min_i(m_errs, 3));
    chk("sat_err_pulse", err_pulse_s, m_pulse);
  endtask

  task automatic step(input bit e, input bit c, input int v, input bit d);
    en = e; clr_err = c; cntr_in = 3'(v); div_in = d;
    @(posedge clk);
    #1;
    model_step(e, c, v, d);
    compare_model();
    $display("t=%0t en=%0b clr=%0b cntr=%0d div=%0b -> state=%0d locked=%0b pulse=%0b err=%0d sat=%0d derr=%0b",
             $time, e, c, v, d, state, locked, err_pulse, err_cnt, err_cnt_s, div_err);
    @(negedge clk);
  endtask

  task automatic cstep(input bit e, input bit c, input int v);
    div_q = ~div_q;
    step(e, c, v, div_q);
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 1, 1, 0, 0, 0};
    tbl[2]  = '{1, 0, 2, 0, 1, 0, 0, 0};
    tbl[3]  = '{1, 0, 3, 1, 1, 0, 0, 0};
    tbl[4]  = '{1, 0, 4, 0, 2, 1, 0, 0};
    tbl[5]  = '{1, 0, 5, 1, 2, 1, 0, 0};
    tbl[6]  = '{1, 0, 6, 0, 2, 1, 0, 0};
    tbl[7]  = '{1, 0, 7, 1, 2, 1, 0, 0};
    tbl[8]  = '{1, 0, 0, 0, 2, 1, 0, 0};
    tbl[9]  = '{1, 0, 1, 1, 2, 1, 0, 0};
    tbl[10] = '{1, 0, 2, 0, 2, 1, 0, 0};
    tbl[11] = '{1, 0, 3, 1, 2, 1, 0, 0};
    tbl[12] = '{1, 0, 4, 0, 2, 1, 0, 0};
    tbl[13] = '{1, 0, 6, 1, 2, 1, 1, 1};
    tbl[14] = '{1, 0, 6, 0, 2, 1, 0, 1};
    tbl[15] = '{1, 0, 7, 1, 2, 1, 0, 1};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_div_err", div_err, 0);
    chk("rst_pulse", err_pulse, 0);
    @(negedge clk);
    rst_b = 1'b1;

    // lock timing, wrap-around and a single glitch
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].cntr, tbl[i].div);
      chk($sformatf("tbl%0d_state", i), state, tbl[i].state);
      chk($sformatf("tbl%0d_locked", i), locked, tbl[i].locked);
      chk($sformatf("tbl%0d_pulse", i), err_pulse, tbl[i].pulse);
      chk($sformatf("tbl%0d_errcnt", i), err_cnt, tbl[i].errcnt);
    end
    chk("tbl_div_err", div_err, 0);
    div_q = 1'b1;

    // stalled stream: three errors, LOST for one cycle, re-acquire
    cstep(1, 1, 0);
    chk("stall_clr", err_cnt, 0);
    cstep(1, 0, 1);
    cstep(1, 0, 2);
    for (int k = 0; k < 3; k++) begin
      cstep(1, 0, 2);
      chk("stall_pulse", err_pulse, 1);
    end
    chk("stall_state_lost", state, 3);
    chk("stall_locked", locked, 0);
    chk("stall_err_cnt", err_cnt, 3);
    cstep(1, 0, 3);
    chk("lost_to_acq", state, 1);
    for (int k = 4; k < 8; k++) cstep(1, 0, k);
    chk("relock", locked, 1);

    // saturation on the 2-bit instance, then a clear colliding with an error
    cstep(1, 1, 0);
    cv = 1;
    for (int k = 0; k < 5; k++) begin
      cstep(1, 0, (cv + 3) % 8);
      cv = (cv + 1) % 8;
      chk("sat_progress", err_cnt_s, min_i(k + 1, 3));
      cstep(1, 0, cv);
      cv = (cv + 1) % 8;
    end
    chk("sat_cap", err_cnt_s, 3);
    chk("sat_wide", err_cnt, 5);
    chk("sat_locked", locked_s, 1);
    cstep(1, 1, (cv + 3) % 8);
    cv = (cv + 1) % 8;
    chk("clr_pulse", err_pulse, 1);
    chk("clr_cnt", err_cnt, 0);
    chk("clr_cnt_sat", err_cnt_s, 0);

    // divided clock stuck at 1 for two samples
    if (div_q) begin
      cstep(1, 0, cv);
      cv = (cv + 1) % 8;
    end
    step(1, 0, cv, 1'b1);
    cv = (cv + 1) % 8;
    chk("div_first_ok", div_err, 0);
    step(1, 0, cv, 1'b1);
    cv = (cv + 1) % 8;
    div_q = 1'b1;
    chk("div_fault", div_err, 1);
    for (int k = 0; k < 3; k++) begin
      cstep(1, 0, cv);
      cv = (cv + 1) % 8;
    end
    chk("div_sticky", div_err, 1);
    chk("div_locked", locked, 1);

    // asynchronous reset mid-lock, checked before any clock edge
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_locked", locked, 0);
    chk("arst_err_cnt", err_cnt, 0);
    chk("arst_div_err", div_err, 0);
    chk("arst_sat_cnt", err_cnt_s, 0);
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;

    // random stimulus against the model
    for (int n = 0; n < 400; n++) begin
      bit e, c, d;
      int v;
      e = ($urandom % 16) != 0;
      c = ($urandom % 32) == 0;
      v = (($urandom % 10) < 8) ? cv : int'($urandom % 8);
      d = (($urandom % 10) < 9) ? ~div_q : div_q;
      div_q = d;
      step(e, c, v, d);
      cv = (cv + 1) % 8;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
